if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue_if.sv | 29 ++
 rtl/if_id_queue.sv | 97 +++++++++
 tb/tb_if_id_queue.sv | 137 +++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the IF/ID instruction queue
interface if_id_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   InstrF;
    logic [31:0]   PCPlus4F;
    logic          ValidF;
    logic          StallD;
    logic          FlushD;
    logic          StallF;
    logic [31:0]   InstrD;
    logic [31:0]   PCPlus4D;
    logic          ValidD;
    logic [CW-1:0] Count;

    // Pipeline side: fetch/decode/hazard logic drives the controls and observes the queue
    modport master (
        output InstrF, PCPlus4F, ValidF, StallD, FlushD,
        input  StallF, InstrD, PCPlus4D, ValidD, Count
    );

    // Queue side
    modport slave (
        input  InstrF, PCPlus4F, ValidF, StallD, FlushD,
        output StallF, InstrD, PCPlus4D, ValidD, Count
    );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - circular IF/ID instruction queue; optional fetch-to-decode bypass under IF_ID_BYPASS_EN
module if_id_queue #(
    parameter int DEPTH = 4
) (
    input  logic          Clk,
    input  logic          rst,
    if_id_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          byp_take;
    logic          valid_d;
    logic [31:0]   instr_d;
    logic [31:0]   pc_d;
    logic [63:0]   head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

`ifdef IF_ID_BYPASS_EN
    logic byp;
    // An empty queue forwards the fetch word straight to decode
    assign byp      = empty && bus.ValidF && !bus.FlushD;
    // A bypassed word that decode accepts is consumed and never stored
    assign byp_take = byp && !bus.StallD;
`else
    assign byp_take = 1'b0;
`endif

    assign push = bus.ValidF && !full && !bus.FlushD && !byp_take;
    assign pop  = !empty && !bus.StallD && !bus.FlushD;

    // Decode-side view: head entry when occupied, forced NOP otherwise
    always_comb begin
        valid_d = !empty;
        instr_d = 32'h0;
        pc_d    = 32'h0;
        if (!empty) begin
            {instr_d, pc_d} = head;
        end
`ifdef IF_ID_BYPASS_EN
        if (byp) begin
            valid_d = 1'b1;
            instr_d = bus.InstrF;
            pc_d    = bus.PCPlus4F;
        end
`endif
    end

    // Storage write; contents are never reset since they are only visible when occupied
    always_ff @(posedge Clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {bus.InstrF, bus.PCPlus4F};
        end
    end

    // Pointer and occupancy update: reset beats flush, flush beats push/pop
    always_ff @(posedge Clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.FlushD) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.StallF   = full;
    assign bus.ValidD   = valid_d;
    assign bus.InstrD   = instr_d;
    assign bus.PCPlus4D = pc_d;
    assign bus.Count    = count;
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue against a queue-based reference model
module tb_if_id_queue;
    localparam int DEPTH = 4;
`ifdef IF_ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic Clk;
    logic rst;
    int   n_total;
    int   n_pass;

    logic [63:0] q[$];

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: drive inputs, check outputs mid-cycle against the model, then advance the model
    task automatic cycle(input logic r, input logic vf, input logic [31:0] ins,
                         input logic [31:0] pc, input logic sd, input logic fd);
        int          n;
        logic        byp;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        rst          = r;
        bus.ValidF   = vf;
        bus.InstrF   = ins;
        bus.PCPlus4F = pc;
        bus.StallD   = sd;
        bus.FlushD   = fd;
        #4;
        n   = q.size();
        byp = BYP && (n == 0) && vf && !fd;
        ev  = (n != 0) || byp;
        if (n != 0) begin
            ei = q[0][63:32];
            ep = q[0][31:0];
        end else if (byp) begin
            ei = ins;
            ep = pc;
        end else begin
            ei = 32'h0;
            ep = 32'h0;
        end
        chk("ValidD",   32'(bus.ValidD), 32'(ev));
        chk("InstrD",   bus.InstrD, ei);
        chk("PCPlus4D", bus.PCPlus4D, ep);
        chk("StallF",   32'(bus.StallF), 32'(n == DEPTH));
        chk("Count",    32'(bus.Count), n);
        @(posedge Clk);
        if (r || fd) begin
            q.delete();
        end else begin
            if (n != 0 && !sd) void'(q.pop_front());
            if (vf && n < DEPTH && !(byp && !sd)) q.push_back({ins, pc});
        end
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        bus.ValidF = 1'b0; bus.InstrF = 32'h0; bus.PCPlus4F = 32'h0;
        bus.StallD = 1'b0; bus.FlushD = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        q.delete();

        // reset then idle
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);

        // fill to full with decode stalled, fifth push must be dropped
        cycle(0, 1, 32'h11111111, 32'd4,  1, 0);
        cycle(0, 1, 32'h22222222, 32'd8,  1, 0);
        cycle(0, 1, 32'h33333333, 32'd12, 1, 0);
        cycle(0, 1, 32'h44444444, 32'd16, 1, 0);
        cycle(0, 1, 32'h55555555, 32'd20, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 32'h0, 32'h0, 0, 0);

        // wrap-around with one resident entry and simultaneous push+pop
        cycle(0, 1, 32'hA0000000, 32'h100, 1, 0);
        for (int i = 1; i <= 10; i++) cycle(0, 1, 32'hA0000000 + i, 32'h100 + 4 * i, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);

        // flush with three queued and a same-cycle incoming word
        cycle(0, 1, 32'hB0000001, 32'h200, 1, 0);
        cycle(0, 1, 32'hB0000002, 32'h204, 1, 0);
        cycle(0, 1, 32'hB0000003, 32'h208, 1, 0);
        cycle(0, 1, 32'hDEADBEEF, 32'h20C, 0, 1);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);

        // reset mid-operation together with flush and push
        cycle(0, 1, 32'hC0000001, 32'h300, 1, 0);
        cycle(0, 1, 32'hC0000002, 32'h304, 1, 0);
        cycle(1, 1, 32'hC0000003, 32'h308, 0, 1);
        cycle(0, 1, 32'hCAFEF00D, 32'h400, 1, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);

        // bypass (or one-cycle latency) from empty
        cycle(0, 1, 32'h20080001, 32'h500, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, $urandom, $urandom,
                  $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 5);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
